// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SLL = 4'd3,
    OP_SUB = 4'd6,
    OP_SLT = 4'd7,
    OP_NOR = 4'd12
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two requester ports, one result port and the contention counter of the ALU arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF,
  parameter int CNT_W = 16
);

  logic             in0_valid, in1_valid;
  logic             in0_ready, in1_ready;
  logic [WIDTH-1:0] in0_a, in0_b, in1_a, in1_b;
  logic [3:0]       in0_op, in1_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_id;
  logic [CNT_W-1:0] conflict_cnt;

  // master = requesters plus result consumer
  modport master (
    output in0_valid, in1_valid, in0_a, in0_b, in1_a, in1_b, in0_op, in1_op, out_ready,
    input  in0_ready, in1_ready, out_valid, out_result, out_zero, out_id, conflict_cnt
  );

  modport slave (
    input  in0_valid, in1_valid, in0_a, in0_b, in1_a, in1_b, in0_op, in1_op, out_ready,
    output in0_ready, in1_ready, out_valid, out_result, out_zero, out_id, conflict_cnt
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU; unknown opcodes yield zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result
);

  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_ADD: o_result = i_a + i_b;
      // shift amounts at or beyond the width flush to zero
      OP_SLL: if (i_b < SH_LIM) o_result = i_a << i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_SLT: o_result[0] = (i_a < i_b);
      OP_NOR: o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two requesters sharing one ALU, with a single
// registered output slot and a saturating contention counter.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic             w_free, w_both, w_gnt0, w_gnt1, w_gnt;
  logic [WIDTH-1:0] w_a, w_b, w_res;
  logic [3:0]       w_op;

  logic             r_last_grant;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_id;
  logic [CNT_W-1:0] r_conflict_cnt;

  assign w_free = !r_out_valid || bus.out_ready;
  assign w_both = bus.in0_valid && bus.in1_valid;

  // Under contention the requester that did not win last time goes first.
  assign w_gnt0 = rst_n && w_free && bus.in0_valid && (!bus.in1_valid || r_last_grant);
  assign w_gnt1 = rst_n && w_free && bus.in1_valid && (!bus.in0_valid || !r_last_grant);
  assign w_gnt  = w_gnt0 || w_gnt1;

  assign w_a  = w_gnt1 ? bus.in1_a  : bus.in0_a;
  assign w_b  = w_gnt1 ? bus.in1_b  : bus.in0_b;
  assign w_op = w_gnt1 ? bus.in1_op : bus.in0_op;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant   <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_id       <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt) begin
        r_last_grant <= w_gnt1;
        r_out_valid  <= 1'b1;
        r_out_result <= w_res;
        r_out_zero   <= (w_res == '0);
        r_out_id     <= w_gnt1;
      end else if (bus.out_ready) begin
        r_out_valid  <= 1'b0;
      end
      if (w_both && (r_conflict_cnt != {CNT_W{1'b1}}))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.in0_ready    = w_gnt0;
  assign bus.in1_ready    = w_gnt1;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_result   = r_out_result;
  assign bus.out_zero     = r_out_zero;
  assign bus.out_id       = r_out_id;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; all ALU semantics SHALL scale with it.
REQ-002 Parameter: CNT_W, 16, width of contention counter.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in0_valid / in1_valid  input  1  requester N presents an operation.
REQ-006 in0_ready / in1_ready  output  1  requester N's operation accepted this cycle when valid&ready.
REQ-007 in0_a, in0_b, in1_a, in1_b  input  WIDTH  operands A, B.
REQ-008 in0_op, in1_op  input  4  ALU opcode.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result when out_valid&out_ready.
REQ-011 out_result  output  WIDTH  registered ALU result.
REQ-012 out_zero  output  1  registered (out_result == 0).
REQ-013 out_id  output  1  index of requester that produced out_result.
REQ-014 conflict_cnt  output  CNT_W  cycles both requesters were valid, saturating.

Function
REQ-015 Opcodes: 0 AND, 1 OR, 2 ADD (mod 2^WIDTH), 3 SLL (A << B, result 0 when B >= WIDTH), 6 SUB (mod 2^WIDTH), 7 SLT unsigned (result 1 or 0, zero-extended), 12 NOR; all other opcodes SHALL produce 0.
REQ-016 Output stage is one register; "slot free" = !out_valid | out_ready.
REQ-017 Grant SHALL be issued only when slot free; at most one grant per cycle; in0_ready/in1_ready SHALL be one-hot or zero.
REQ-018 Only one valid: that requester granted. Both valid: requester other than last_grant granted (round-robin).
REQ-019 last_grant SHALL update to granted index on every grant; reset value 1 (so in0 wins the first contention).
REQ-020 Readies SHALL depend combinationally on valids, out_valid, out_ready, last_grant; valids SHALL NOT depend on readies.
REQ-021 Latency: operation accepted in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1.
REQ-022 Simultaneous consume and grant: out_result/out_zero/out_id SHALL load the new operation, out_valid stays 1; full throughput one op/cycle.
REQ-023 Consume with no grant: out_valid SHALL clear next cycle; out_result/out_zero/out_id SHALL hold.
REQ-024 out_valid=1, out_ready=0: out_result, out_zero, out_id SHALL hold stable; both readies 0.
REQ-025 conflict_cnt SHALL increment by 1 each cycle in0_valid&in1_valid, regardless of slot state, saturating at 2^CNT_W-1.
REQ-026 Requester dropping valid without handshake SHALL be permitted; no state change results.

Reset
REQ-027 rst_n=0 sampled at a clock edge: out_valid=0, out_result=0, out_zero=0, out_id=0, conflict_cnt=0, last_grant=1.
REQ-028 While rst_n=0, in0_ready and in1_ready SHALL be 0.
REQ-029 Reset mid-operation SHALL discard the held result with no handshake; first grant possible the cycle after rst_n returns 1.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode enum (AND, OR, ADD, SLL, SUB, SLT, NOR) and WIDTH default constant.
REQ-031 Combinational ALU SHALL be one sub-module, alu_core (A, B, op -> result), instantiated once, driven by the granted requester's operands via a mux.
REQ-032 Arbitration, output register, counter SHALL be in alu_arbiter; no other sub-modules.

Verification
REQ-033 Single port: in0 valid, A=5,B=3,op=2, out_ready=1 -> next cycle out_valid=1, out_result=8, out_zero=0, out_id=0.
REQ-034 Contention after reset: both valid every cycle, in0 SUB 7-7, in1 OR 1|2, out_ready=1 -> out_id 0,1,0,1...; first result 0 with out_zero=1, second 3; conflict_cnt increments each cycle.
REQ-035 Backpressure: out_ready=0 for 4 cycles with result 0x10 held -> readies 0, out_* stable; out_ready=1 with in1 valid -> same-cycle grant, next result loaded, out_valid stays 1.
REQ-036 Opcode sweep: A=0xFFFF0000, B=0x0000FFFF over all 16 opcodes -> AND 0, OR 0xFFFFFFFF, ADD 0xFFFFFFFF, SUB 0xFFFE0001, SLT 0, NOR 0, undefined 0; SLL with B=32 -> 0.
REQ-037 Reset mid-operation: out_valid=1, out_ready=0, assert rst_n=0 one cycle -> out_valid=0, conflict_cnt=0, next contention granted to in0.
REQ-038 Saturation with CNT_W=3: both valid 10 cycles -> conflict_cnt stops at 7.
